i2c_master_controller: RTL
==========================

# i2c_master_controller

Single-byte I2C master (initiator) for the on-chip I2C bus. On a one-cycle `start` request it generates START, sends a 7-bit address plus R/W bit, then writes one byte to or reads one byte from the addressed target, and finishes with STOP. It drives the same open-drain `i2c_sda`/`i2c_scl` lines that `i2c_slave_controller` responds on. It is used as the bus-side engine for register access and for bench loopback against the slave.

## Interface
- `DIV`, 4: system clocks per SCL quarter-period; SCL period = 4*`DIV` clocks; legal range 1..255.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  one-cycle transaction request; accepted only when `busy`=0.
- `addr`  input  7  target address, latched on accept.
- `rw`  input  1  1 = read, 0 = write; latched on accept.
- `data_in`  input  8  write byte, latched on accept.
- `data_out`  output  8  read byte; updated at end of a read transaction, otherwise holds.
- `busy`  output  1  high from the cycle after accept until `done`.
- `done`  output  1  one-cycle pulse at end of every transaction, success or error.
- `ack_error`  output  1  set with `done` if address or write-data ACK was missing; cleared on next accept.
- `i2c_sda`  inout  1  open-drain; drives 0 or Z only.
- `i2c_scl`  inout  1  open-drain; drives 0 or Z only.

## Operation
- Reset values: `data_out`=0, `busy`=0, `done`=0, `ack_error`=0, SDA and SCL released (Z), state IDLE, divider and bit counters 0.
- Each bus bit occupies 4 quarters of `DIV` clocks:
  - Q0: SCL low; SDA updated on the first clock of Q0.
  - Q1: SCL low.
  - Q2: SCL released.
  - Q3: SCL released.
  - SDA is sampled on the last clock of Q2.
- States:
  - IDLE: lines released. On `start` && !`busy`, latch inputs, clear `ack_error`, go to START.
  - START: Q0–Q1 SDA and SCL released; Q2–Q3 SDA low with SCL released (START condition); then ADDR.
  - ADDR: 8 bits, MSB first: `addr[6:0]` then `rw`.
  - ADDR_ACK: SDA released, sampled. 0 → WRITE_DATA if `rw`=0, READ_DATA if `rw`=1. 1 → set error flag, go to STOP.
  - WRITE_DATA: 8 bits of latched `data_in`, MSB first; then WRITE_ACK.
  - WRITE_ACK: SDA released and sampled; 1 sets error flag; always go to STOP.
  - READ_DATA: SDA released; 8 samples shifted in MSB first; then READ_ACK.
  - READ_ACK: master releases SDA (NACK, last byte); go to STOP.
  - STOP: Q0–Q1 SCL low, SDA low; Q2 SCL released, SDA low; Q3 SDA released (STOP condition). Then pulse `done`, load `data_out` (read only), drive `ack_error`, go to IDLE.
- No clock stretching, no arbitration, no repeated START. SCL is not monitored.
- Read is flagged only on address NACK; data NACK in a read is the master's own.

## Timing
- Accepted `start` at cycle T: `busy`=1 at T+1. First START quarter begins at T+1.
- Successful transaction (read or write): START 4*`DIV` + 9 bits 36*`DIV` + 9 bits 36*`DIV` + STOP 4*`DIV` = 80*`DIV` clocks. `done` is high at cycle T+1+80*`DIV`, and `busy` falls in that same cycle.
- Address NACK: 44*`DIV` clocks to `done`.
- `start` while `busy`=1 is ignored entirely. A new `start` is legal in the `done` cycle's successor.
- `start` in the same cycle as `rst`: `rst` wins.
- `rst` mid-transaction: the next edge returns to IDLE, releases both lines, and zeroes all outputs. No STOP is generated.
- Divider counts 0..`DIV`-1 per quarter and wraps. Quarter counter wraps 3→0. Bit counter counts 7..0.

## Test plan
- Write, `DIV`=4, `addr`=0x50, `rw`=0, `data_in`=0xA5, slave model ACKs → SDA bytes 0xA0 then 0xA5, `done` at T+321, `ack_error`=0.
- Read, `addr`=0x50, `rw`=1, slave returns 0x3C → address byte 0xA1, `data_out`=0x3C at `done`, master NACK seen on the 9th data-phase bit.
- No device at `addr`=0x11 (SDA floats high) → STOP immediately after ADDR_ACK, `done` at T+177, `ack_error`=1, `data_out` unchanged.
- Assert `rst` for 1 cycle during write data bit 3 → next cycle: lines Z, `busy`=0, `done`=0, `ack_error`=0; a fresh `start` completes normally.
- `start` re-pulsed at T+50 during busy → ignored; exactly one `done`; bus bytes match the first request.
- Bit-timing check with `DIV`=1 and `DIV`=7 → SCL high and low each 2*`DIV` clocks; SDA never changes while SCL is high except at START/STOP.

Source files
------------

// File: rtl/i2c_master_controller.sv
// ---------------------------------------------------------------------------
// i2c_master_controller
//
// Single-byte I2C master. A one-cycle `start` request (taken only while idle)
// produces START, a 7-bit address plus R/W bit, one data byte written to or
// read from the target, and STOP. Every bus bit is four quarters of DIV
// system clocks. SCL is low in Q0/Q1 and released in Q2/Q3. SDA changes on
// the first clock of Q0 and is sampled on the last clock of Q2.
//
// Parameters
//   DIV        system clocks per SCL quarter period (1..255)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle transaction request, accepted when busy = 0
//   addr[6:0]  target address, latched on accept
//   rw         1 = read, 0 = write, latched on accept
//   data_in    byte to write, latched on accept
//   data_out   byte read; loaded at the end of a successful read, else holds
//   busy       high from the cycle after accept until done
//   done       one-cycle pulse at the end of every transaction
//   ack_error  address or write-data ACK missing; valid with done,
//              cleared on the next accept
//   i2c_sda    open-drain data line (drives 0 or Z)
//   i2c_scl    open-drain clock line (drives 0 or Z)
// ---------------------------------------------------------------------------
module i2c_master_controller #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  inout  wire        i2c_sda,
  inout  wire        i2c_scl
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE_DATA,
    ST_WRITE_ACK,
    ST_READ_DATA,
    ST_READ_ACK,
    ST_STOP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  // Bus position: state, quarter within the bit, clock within the quarter,
  // and the data bit index (7 down to 0).
  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [1:0] quarter_q, quarter_d;
  logic [2:0] bit_q, bit_d;

  // Request registers latched on accept.
  logic [6:0] addr_q, addr_d;
  logic       rw_q, rw_d;
  logic [7:0] wdata_q, wdata_d;

  // Read shift register and the running error flag for this transaction.
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;

  // Registered outputs.
  logic [7:0] data_out_q, data_out_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ack_error_q, ack_error_d;
  logic       scl_low_q, scl_low_d;
  logic       sda_low_q, sda_low_d;

  logic       quarter_end;
  logic       bit_end;
  logic       sample_now;
  logic       sda_in;
  logic [7:0] addr_byte;

  assign sda_in    = i2c_sda;
  assign addr_byte = {addr_q, rw_q};

  assign quarter_end = (div_q == DIV_LAST);
  assign bit_end     = quarter_end && (quarter_q == 2'd3);
  assign sample_now  = quarter_end && (quarter_q == 2'd2);

  // Next-state logic. The line drivers are computed from the *next* bus
  // position so that the registered SCL/SDA values line up exactly with the
  // registered position (SDA therefore changes on the first clock of Q0).
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    quarter_d   = quarter_q;
    bit_d       = bit_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    data_out_d  = data_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ack_error_d = ack_error_q;
    scl_low_d   = 1'b0;
    sda_low_d   = 1'b0;

    if (state_q != ST_IDLE) begin
      if (quarter_end) begin
        div_d     = 8'd0;
        quarter_d = quarter_q + 2'd1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !busy_q) begin
          addr_d      = addr;
          rw_d        = rw;
          wdata_d     = data_in;
          err_d       = 1'b0;
          ack_error_d = 1'b0;
          busy_d      = 1'b1;
          div_d       = 8'd0;
          quarter_d   = 2'd0;
          bit_d       = 3'd0;
          state_d     = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          bit_d   = 3'd7;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (bit_end) begin
          if (bit_q == 3'd0) begin
            state_d = ST_ADDR_ACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end

      // The ACK sample lands one or more clocks before the end of the bit,
      // so err_q is already settled when the branch is taken.
      ST_ADDR_ACK: begin
        if (sample_now && sda_in) begin
          err_d = 1'b1;
        end
        if (bit_end) begin
          bit_d = 3'd7;
          if (err_q) begin
            state_d = ST_STOP;
          end else if (rw_q) begin
            state_d = ST_READ_DATA;
          end else begin
            state_d = ST_WRITE_DATA;
          end
        end
      end

      ST_WRITE_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd0) begin
            state_d = ST_WRITE_ACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end

      ST_WRITE_ACK: begin
        if (sample_now && sda_in) begin
          err_d = 1'b1;
        end
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end

      ST_READ_DATA: begin
        if (sample_now) begin
          rdata_d = {rdata_q[6:0], sda_in};
        end
        if (bit_end) begin
          if (bit_q == 3'd0) begin
            state_d = ST_READ_ACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end

      // Master NACKs the only byte it reads by leaving SDA released.
      ST_READ_ACK: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end

      // A read that failed at the address phase must leave data_out alone,
      // hence the err_q gate on the load.
      ST_STOP: begin
        if (bit_end) begin
          state_d     = ST_IDLE;
          div_d       = 8'd0;
          quarter_d   = 2'd0;
          bit_d       = 3'd0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          ack_error_d = err_q;
          if (rw_q && !err_q) begin
            data_out_d = rdata_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_START: begin
        sda_low_d = quarter_d[1];
      end
      ST_ADDR: begin
        scl_low_d = !quarter_d[1];
        sda_low_d = !addr_byte[bit_d];
      end
      ST_WRITE_DATA: begin
        scl_low_d = !quarter_d[1];
        sda_low_d = !wdata_q[bit_d];
      end
      ST_ADDR_ACK, ST_WRITE_ACK, ST_READ_DATA, ST_READ_ACK: begin
        scl_low_d = !quarter_d[1];
      end
      // SDA held low through Q2 with SCL high, then released in Q3.
      ST_STOP: begin
        scl_low_d = !quarter_d[1];
        sda_low_d = (quarter_d != 2'd3);
      end
      default: begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
      end
    endcase
  end

  // All state and outputs in one register bank. Reset abandons any
  // transaction without a STOP and releases both lines immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_q       <= 8'd0;
      quarter_q   <= 2'd0;
      bit_q       <= 3'd0;
      addr_q      <= 7'd0;
      rw_q        <= 1'b0;
      wdata_q     <= 8'd0;
      rdata_q     <= 8'd0;
      err_q       <= 1'b0;
      data_out_q  <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_error_q <= 1'b0;
      scl_low_q   <= 1'b0;
      sda_low_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      quarter_q   <= quarter_d;
      bit_q       <= bit_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      data_out_q  <= data_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_error_q <= ack_error_d;
      scl_low_q   <= scl_low_d;
      sda_low_q   <= sda_low_d;
    end
  end

  assign data_out  = data_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = ack_error_q;

  assign i2c_scl = scl_low_q ? 1'b0 : 1'bz;
  assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;

endmodule
